// File: rtl/decode_fwd_stage.sv
// Decode stage with operand forwarding, hazard stall and a one-entry output register.
// Optional feature: define DECODE_ILLEGAL_TRAP_EN to flag unsupported opcodes via out_illegal.
module decode_fwd_stage #(
    parameter int XLEN  = 32,
    parameter int NFWD  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          inst,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      s1,
    input  logic [XLEN-1:0]      s2,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_busy,
    input  logic [NFWD*5-1:0]    fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_op1,
    output logic [XLEN-1:0]      out_op2,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_pc,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic [6:0]           out_opcode,
    output logic [2:0]           out_funct3,
    output logic                 out_funct7b5,
    output logic                 out_map_en,
    output logic                 out_illegal,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    // Returns {stall, operand}; the lowest-index matching source wins.
    function automatic logic [XLEN:0] resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf);
        logic [XLEN-1:0] data;
        logic            stall;
        logic            found;
        data  = rf;
        stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < NFWD; i++) begin
            if (!found && (fwd_valid[i] || fwd_busy[i]) && fwd_rd[i*5 +: 5] == rs) begin
                found = 1'b1;
                if (fwd_valid[i]) data = fwd_data[i*XLEN +: XLEN];
                else              stall = 1'b1;
            end
        end
        if (rs == 5'd0) begin
            data  = '0;
            stall = 1'b0;
        end
        return {stall, data};
    endfunction

    logic [XLEN:0]   res1, res2;
    logic            use_rs1, use_rs2;
    logic            hazard;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_next;
    logic            map_en_next;
    logic            illegal_next;
    logic            xfer;

    always_comb begin
        res1 = resolve(rs1, s1);
        res2 = resolve(rs2, s2);

        use_rs1 = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
                  (opcode == OPC_STORE) || (opcode == OPC_BRANCH) || (opcode == OPC_JALR);
        use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
        hazard  = (use_rs1 && res1[XLEN]) || (use_rs2 && res2[XLEN]);

        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm32 = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {inst[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        imm_next = XLEN'($signed(imm32));

        map_en_next = (rd != 5'd0) &&
                      ((opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
                       (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                       (opcode == OPC_JALR));

`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_next = !(use_rs1 || (opcode == OPC_LUI) || (opcode == OPC_AUIPC) ||
                         (opcode == OPC_JAL));
`else
        illegal_next = 1'b0;
`endif
    end

    assign in_ready = !hazard && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_op1      <= '0;
            out_op2      <= '0;
            out_imm      <= '0;
            out_pc       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rd       <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_map_en   <= 1'b0;
            out_illegal  <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            if (flush)                      out_valid <= 1'b0;
            else if (xfer)                  out_valid <= 1'b1;
            else if (out_valid && out_ready) out_valid <= 1'b0;

            if (xfer) begin
                out_op1      <= res1[XLEN-1:0];
                out_op2      <= res2[XLEN-1:0];
                out_imm      <= imm_next;
                out_pc       <= pc;
                out_rs1      <= rs1;
                out_rs2      <= rs2;
                out_rd       <= rd;
                out_opcode   <= opcode;
                out_funct3   <= inst[14:12];
                out_funct7b5 <= inst[30];
                out_map_en   <= map_en_next;
                out_illegal  <= illegal_next;
            end

            if (in_valid && hazard && !flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_fwd_stage.sv
// Directed bench for decode_fwd_stage: RF read, forwarding, hazards, backpressure, flush, immediates, reset.
module tb_decode_fwd_stage;

    localparam int XLEN  = 32;
    localparam int NFWD  = 2;
    localparam int CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]          inst;
    logic [XLEN-1:0]      pc, s1, s2;
    logic [NFWD-1:0]      fwd_valid, fwd_busy;
    logic [NFWD*5-1:0]    fwd_rd;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [XLEN-1:0]      out_op1, out_op2, out_imm, out_pc;
    logic [4:0]           out_rs1, out_rs2, out_rd;
    logic [6:0]           out_opcode;
    logic [2:0]           out_funct3;
    logic                 out_funct7b5, out_map_en, out_illegal;
    logic [CNT_W-1:0]     stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_ill;

    always #5 clk = ~clk;

    decode_fwd_stage #(.XLEN(XLEN), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .s1(s1), .s2(s2),
        .fwd_valid(fwd_valid), .fwd_busy(fwd_busy), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_map_en(out_map_en), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inst = 32'h0; pc = 32'h0; s1 = 32'd2; s2 = 32'd1;
        fwd_valid = '0; fwd_busy = '0; fwd_rd = '0; fwd_data = '0;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_op1", out_op1, 0);
        chk("rst_rd", out_rd, 0);

        // add x3,x1,x2 from the register file
        rst = 1'b0; in_valid = 1'b1; inst = 32'h002081B3; pc = 32'h100;
        #1 chk("rf_in_ready", in_ready, 1);
        tick();
        chk("rf_valid", out_valid, 1);
        chk("rf_op1", out_op1, 2);
        chk("rf_op2", out_op2, 1);
        chk("rf_rd", out_rd, 3);
        chk("rf_map_en", out_map_en, 1);
        chk("rf_imm", out_imm, 0);
        chk("rf_pc", out_pc, 32'h100);
        chk("rf_opcode", out_opcode, 7'h33);

        // both sources target x1: source 0 wins
        fwd_valid = 2'b11; fwd_rd = {5'd1, 5'd1}; fwd_data = {32'hBB, 32'hAA};
        tick();
        chk("fwd_prio_op1", out_op1, 32'hAA);
        chk("fwd_prio_op2", out_op2, 1);

        // rs1 = x0 with a source writing x0
        inst = 32'h002001B3; fwd_rd = {5'd1, 5'd0};
        tick();
        chk("x0_op1", out_op1, 0);
        chk("x0_op2", out_op2, 1);

        // source 1 allocated for x2 but not ready
        inst = 32'h002081B3; fwd_valid = 2'b00; fwd_busy = 2'b10; fwd_rd = {5'd2, 5'd0};
        for (int i = 0; i < 3; i++) begin
            #1 chk("haz_in_ready", in_ready, 0);
            tick();
        end
        chk("haz_stall3", stall_cnt, 3);
        chk("haz_out_valid", out_valid, 0);
        fwd_valid = 2'b10; fwd_data = {32'd7, 32'd0};
        #1 chk("haz_release", in_ready, 1);
        tick();
        chk("haz_valid", out_valid, 1);
        chk("haz_op1", out_op1, 2);
        chk("haz_op2", out_op2, 7);
        chk("haz_stall_hold", stall_cnt, 3);

        // backpressure with lui x5,0x12345 waiting
        fwd_valid = '0; fwd_busy = '0; out_ready = 1'b0; inst = 32'h123452B7; pc = 32'h200;
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp_in_ready", in_ready, 0);
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_op2", out_op2, 7);
            chk("bp_rd", out_rd, 3);
        end
        flush = 1'b1; out_ready = 1'b1;
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_no_capture", out_rd, 3);
        flush = 1'b0;
        tick();
        chk("lui_valid", out_valid, 1);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_rd", out_rd, 5);
        chk("lui_map_en", out_map_en, 1);
        chk("lui_pc", out_pc, 32'h200);

        // beq x1,x2,-4
        inst = 32'hFE208EE3;
        tick();
        chk("b_imm", out_imm, 32'hFFFFFFFC);
        chk("b_map_en", out_map_en, 0);
        chk("b_rs2", out_rs2, 2);

        // sw x2,-8(x1)
        inst = 32'hFE20AC23;
        tick();
        chk("s_imm", out_imm, 32'hFFFFFFF8);
        chk("s_funct3", out_funct3, 2);
        chk("s_map_en", out_map_en, 0);

        // jal x1,8
        inst = 32'h008000EF;
        tick();
        chk("j_imm", out_imm, 8);
        chk("j_map_en", out_map_en, 1);

        // opcode 0x7F with rd=10
        inst = 32'h0000057F;
`ifdef DECODE_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        tick();
        chk("ill_flag", out_illegal, exp_ill);
        chk("ill_map_en", out_map_en, 0);
        chk("ill_imm", out_imm, 0);
        chk("ill_rd", out_rd, 10);

        // flush suppresses stall counting, then saturate the counter
        inst = 32'h002081B3; fwd_busy = 2'b10; fwd_rd = {5'd2, 5'd0}; flush = 1'b1;
        tick();
        chk("flush_stall_hold", stall_cnt, 3);
        flush = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("stall_sat", stall_cnt, 15);
        tick(); tick();
        chk("stall_sat_hold", stall_cnt, 15);

        // reset while an instruction is held
        fwd_busy = '0; out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        chk("mid_rst_rd", out_rd, 0);
        chk("mid_rst_op1", out_op1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_fwd_stage.md
DECODE_FWD_STAGE -- requirements
Module: decode_fwd_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and PC width.
REQ-002 SHALL have parameter NFWD, default 2, meaning number of forwarding sources; index 0 is youngest and highest priority.
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall counter width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  discard the held instruction.
REQ-007 in_valid / in_ready  in / out  1 / 1  upstream handshake.
REQ-008 inst, pc  in  32 / XLEN  fetched instruction and its PC.
REQ-009 s1, s2  in  XLEN each  register-file read data for rs1 and rs2.
REQ-010 fwd_valid, fwd_busy  in  NFWD each  per source: result data valid / destination allocated but data not yet produced.
REQ-011 fwd_rd, fwd_data  in  NFWD*5 / NFWD*XLEN  per-source destination index and data, packed with source i at [i*W +: W].
REQ-012 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-013 out_op1, out_op2, out_imm, out_pc  out  XLEN each  resolved operands, sign-extended immediate, PC.
REQ-014 out_rs1, out_rs2, out_rd  out  5 each; out_opcode  out  7; out_funct3  out  3; out_funct7b5  out  1.
REQ-015 out_map_en  out  1  instruction writes rd and rd != 0.
REQ-016 out_illegal  out  1  unsupported opcode; stall_cnt  out  CNT_W  hazard-stall cycle count.

Function
REQ-017 Operand resolution: for each of rs1 and rs2, when rsN == 0 the operand SHALL be 0; otherwise the lowest-index source i with (fwd_valid[i] | fwd_busy[i]) and fwd_rd[i] == rsN SHALL be selected; if that source has fwd_valid[i] set, the operand SHALL be fwd_data[i]; if no source matches, the operand SHALL be s1 or s2.
REQ-018 Hazard: the hazard condition SHALL be true when the selected source for a used rs has fwd_busy set and fwd_valid clear.
REQ-019 An rs SHALL count as used by opcode: rs1 for OP, OP-IMM, LOAD, STORE, BRANCH, JALR; rs2 for OP, STORE, BRANCH only.
REQ-020 in_ready SHALL equal !hazard & (!out_valid | out_ready); an input transfer SHALL occur when in_valid & in_ready.
REQ-021 On a transfer, all out_* fields SHALL be registered from the current inputs, and out_valid SHALL be 1 from the next cycle; latency SHALL be 1 cycle.
REQ-022 When out_valid & out_ready are both 1 and no new transfer occurs, out_valid SHALL clear; when a transfer occurs in the same cycle, out_valid SHALL stay 1 with the new fields.
REQ-023 While out_valid & !out_ready, all out_* fields SHALL hold stable.
REQ-024 Immediate by type, sign-extended to XLEN: I (OP-IMM, LOAD, JALR), S, B, U (LUI, AUIPC), J (JAL); all other opcodes SHALL produce 0.
REQ-025 out_map_en SHALL be 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR when rd != 0, and 0 otherwise.
REQ-026 flush SHALL clear out_valid next cycle and block any transfer in the same cycle; flush SHALL take priority over every handshake.
REQ-027 stall_cnt SHALL increment by 1 each cycle with in_valid & hazard & !flush, and SHALL saturate at all-ones.

Reset
REQ-028 rst SHALL set out_valid=0, stall_cnt=0, and every other out_* register to 0, with priority over flush and transfers.
REQ-029 rst asserted mid-operation SHALL drop the held instruction with no partial output.

Configuration
REQ-030 With DECODE_ILLEGAL_TRAP_EN defined, opcodes outside {OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR} SHALL set out_illegal=1 and force out_map_en=0.
REQ-031 Without DECODE_ILLEGAL_TRAP_EN, out_illegal SHALL be tied 0 and unknown opcodes SHALL pass through with imm=0 and map_en=0.

Verification
REQ-032 Reset and RF read: rst for 2 cycles, then inst=0x002081B3 (add x3,x1,x2), s1=2, s2=1, no forwarding -> out_valid=1 next cycle, op1=2, op2=1, rd=3, map_en=1.
REQ-033 Forwarding priority: same inst; fwd0 and fwd1 both valid with rd=1, data 0xAA and 0xBB -> op1=0xAA; x0 source: rs1=0 with a source targeting rd 0 -> op1=0.
REQ-034 Hazard: fwd_busy[1]=1, fwd_valid[1]=0, fwd_rd[1]=2 for the add -> in_ready=0 for 3 cycles with stall_cnt=3; then fwd_valid[1]=1 with data 7 -> transfer occurs, op2=7.
REQ-035 Backpressure and flush: out_ready=0 for 4 cycles -> fields stable and in_ready=0; then flush=1 -> out_valid=0 next cycle, and the input presented during flush is not captured.
REQ-036 Immediates and illegal: B-type with imm=-4 -> out_imm=0xFFFFFFFC; opcode 0x7F with DECODE_ILLEGAL_TRAP_EN defined -> out_illegal=1, map_en=0; stall_cnt forced near all-ones -> stall_cnt holds at all-ones.
